// File: rtl/bus_xbar.sv
// NUM_M x NUM_S memory-bus crossbar: per-slave arbitration (round-robin or fixed), master lock,
// registered read-return routing. Define BUS_DECERR_EN to terminate unmapped accesses with an error.
module bus_xbar #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int ARB_RR = 1,
  parameter logic [4*NUM_S-1:0] S_BASE = {4'h8, 4'h4, 4'h2, 4'h1}
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_M-1:0]         i_m_req,
  input  logic [NUM_M-1:0]         i_m_lock,
  output logic [NUM_M-1:0]         o_m_gnt,
  input  logic [NUM_M*ADDR_W-1:0]  i_m_addr,
  input  logic [NUM_M-1:0]         i_m_write,
  input  logic [NUM_M-1:0]         i_m_read,
  input  logic [NUM_M*4-1:0]       i_m_size,
  input  logic [NUM_M*DATA_W-1:0]  i_m_din,
  output logic [NUM_M*DATA_W-1:0]  o_m_dout,
  output logic [NUM_M-1:0]         o_m_rvalid,
  output logic [NUM_M-1:0]         o_m_err,
  output logic [NUM_S*ADDR_W-1:0]  o_s_addr,
  output logic [NUM_S-1:0]         o_s_write,
  output logic [NUM_S-1:0]         o_s_read,
  output logic [NUM_S*4-1:0]       o_s_size,
  output logic [NUM_S*DATA_W-1:0]  o_s_din,
  input  logic [NUM_S*DATA_W-1:0]  i_s_dout
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
`ifdef BUS_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [SW-1:0]    tgt [NUM_M];
  logic [NUM_M-1:0] hit, routed;
  logic [NUM_M-1:0] cand [NUM_S];
  logic [MW-1:0]    win [NUM_S];
  logic [NUM_S-1:0] s_gnt, held;

  logic [MW-1:0]    rr_ptr_q [NUM_S], rr_ptr_d [NUM_S];
  logic [MW-1:0]    lock_own_q [NUM_S], lock_own_d [NUM_S];
  logic [NUM_S-1:0] lock_vld_q, lock_vld_d;
  logic [RD_LAT-1:0] pv_q [NUM_M], pe_q [NUM_M];
  logic [SW-1:0]    ps_q [NUM_M][RD_LAT];
  logic [NUM_M-1:0] wr_err_q;

  // Address decode; scanning downward lets the lowest matching slave win.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      tgt[m] = '0;
      hit[m] = 1'b0;
      for (int s = NUM_S - 1; s >= 0; s--) begin
        if (S_BASE[4*s +: 4] == i_m_addr[m*ADDR_W + ADDR_W - 4 +: 4]) begin
          tgt[m] = SW'(s);
          hit[m] = 1'b1;
        end
      end
      routed[m] = hit[m] || !DECERR;
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      win[s]   = '0;
      s_gnt[s] = 1'b0;
      held[s]  = 1'b0;
      for (int m = 0; m < NUM_M; m++)
        cand[s][m] = i_m_req[m] && routed[m] && (tgt[m] == SW'(s));
      if (lock_vld_q[s] && cand[s][lock_own_q[s]] && i_m_lock[lock_own_q[s]]) begin
        win[s]   = lock_own_q[s];
        s_gnt[s] = 1'b1;
        held[s]  = 1'b1;
      end else if (ARB_RR != 0) begin
        // Search farthest-first so the candidate nearest after rr_ptr overrides.
        for (int k = NUM_M; k >= 1; k--) begin
          if (cand[s][(int'(rr_ptr_q[s]) + k) % NUM_M]) begin
            win[s]   = MW'((int'(rr_ptr_q[s]) + k) % NUM_M);
            s_gnt[s] = 1'b1;
          end
        end
      end else begin
        for (int m = NUM_M - 1; m >= 0; m--) begin
          if (cand[s][m]) begin
            win[s]   = MW'(m);
            s_gnt[s] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    o_m_gnt   = '0;
    o_s_addr  = '0;
    o_s_write = '0;
    o_s_read  = '0;
    o_s_size  = '0;
    o_s_din   = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (s_gnt[s]) begin
        o_m_gnt[win[s]]               = 1'b1;
        o_s_addr[s*ADDR_W +: ADDR_W]  = i_m_addr[int'(win[s])*ADDR_W +: ADDR_W];
        o_s_write[s]                  = i_m_write[win[s]];
        o_s_read[s]                   = i_m_read[win[s]];
        o_s_size[s*4 +: 4]            = i_m_size[int'(win[s])*4 +: 4];
        o_s_din[s*DATA_W +: DATA_W]   = i_m_din[int'(win[s])*DATA_W +: DATA_W];
      end
    end
    // Unmapped accesses (error build only) are accepted without a slave.
    for (int m = 0; m < NUM_M; m++)
      if (i_m_req[m] && !routed[m]) o_m_gnt[m] = 1'b1;
  end

  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      rr_ptr_d[s]   = rr_ptr_q[s];
      lock_own_d[s] = lock_own_q[s];
      lock_vld_d[s] = 1'b0;
      if (s_gnt[s]) begin
        if (!held[s]) rr_ptr_d[s] = win[s];
        if (i_m_lock[win[s]]) begin
          lock_vld_d[s] = 1'b1;
          lock_own_d[s] = win[s];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_S; s++) begin
        rr_ptr_q[s]   <= MW'(NUM_M - 1);
        lock_own_q[s] <= '0;
      end
      lock_vld_q <= '0;
      wr_err_q   <= '0;
      for (int m = 0; m < NUM_M; m++) begin
        pv_q[m] <= '0;
        pe_q[m] <= '0;
        for (int i = 0; i < RD_LAT; i++) ps_q[m][i] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_S; s++) begin
        rr_ptr_q[s]   <= rr_ptr_d[s];
        lock_own_q[s] <= lock_own_d[s];
      end
      lock_vld_q <= lock_vld_d;
      for (int m = 0; m < NUM_M; m++) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          pv_q[m][i] <= pv_q[m][i-1];
          pe_q[m][i] <= pe_q[m][i-1];
          ps_q[m][i] <= ps_q[m][i-1];
        end
        pv_q[m][0]  <= o_m_gnt[m] && i_m_read[m];
        pe_q[m][0]  <= !routed[m];
        ps_q[m][0]  <= tgt[m];
        wr_err_q[m] <= o_m_gnt[m] && i_m_write[m] && !routed[m];
      end
    end
  end

  always_comb begin
    o_m_dout = '0;
    for (int m = 0; m < NUM_M; m++) begin
      o_m_rvalid[m] = pv_q[m][RD_LAT-1];
      o_m_err[m]    = DECERR && ((pv_q[m][RD_LAT-1] && pe_q[m][RD_LAT-1]) || wr_err_q[m]);
      if (pv_q[m][RD_LAT-1])
        o_m_dout[m*DATA_W +: DATA_W] = pe_q[m][RD_LAT-1] ? ERR_DATA :
                                       i_s_dout[int'(ps_q[m][RD_LAT-1])*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_xbar.sv
// Bench for bus_xbar: a round-robin/RD_LAT=1 instance and a fixed-priority/RD_LAT=2 instance
// share one stimulus; directed vectors plus random traffic against a reference model.
module tb_bus_xbar;
  localparam int NM = 3;
  localparam int NS = 4;
  localparam logic [15:0] SB = {4'h8, 4'h4, 4'h2, 4'h1};
`ifdef BUS_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   req, lock, rd, wr;
  logic [95:0]  addr, din;
  logic [11:0]  size;
  logic [127:0] sdout;

  logic [2:0]   gnt [2], rv [2], err [2];
  logic [95:0]  dout [2];
  logic [127:0] saddr [2], sdin [2];
  logic [3:0]   srd [2], swr [2];
  logic [15:0]  ssz [2];

  bus_xbar #(.RD_LAT(1), .ARB_RR(1)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req), .i_m_lock(lock), .o_m_gnt(gnt[0]),
    .i_m_addr(addr), .i_m_write(wr), .i_m_read(rd), .i_m_size(size), .i_m_din(din),
    .o_m_dout(dout[0]), .o_m_rvalid(rv[0]), .o_m_err(err[0]), .o_s_addr(saddr[0]),
    .o_s_write(swr[0]), .o_s_read(srd[0]), .o_s_size(ssz[0]), .o_s_din(sdin[0]),
    .i_s_dout(sdout));

  bus_xbar #(.RD_LAT(2), .ARB_RR(0)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req), .i_m_lock(lock), .o_m_gnt(gnt[1]),
    .i_m_addr(addr), .i_m_write(wr), .i_m_read(rd), .i_m_size(size), .i_m_din(din),
    .o_m_dout(dout[1]), .o_m_rvalid(rv[1]), .o_m_err(err[1]), .o_s_addr(saddr[1]),
    .o_s_write(swr[1]), .o_s_read(srd[1]), .o_s_size(ssz[1]), .o_s_din(sdin[1]),
    .i_s_dout(sdout));

  typedef struct { int due; int sl; } rd_t;
  typedef struct {
    logic [2:0]  req, lock, rd, wr;
    logic [31:0] a0, a1, a2;
    logic [2:0]  g_rr, g_fp, rv_rr;
    logic [3:0]  srd, swr;
  } vec_t;

  rd_t        pend [6][$];
  int         last [2][4], lko [2][4], win [2][4];
  bit         held [2][4];
  bit         wrerr [2][3];
  logic [2:0] mgnt [2];
  int         cyc, npass, nchk;
  vec_t       tbl [14];
  logic [3:0] nibs [10];

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
  endtask

  function automatic int tgt_of(int m);
    logic [3:0] nib;
    nib = addr[m*32+28 +: 4];
    for (int s = 0; s < NS; s++) if (SB[s*4 +: 4] == nib) return s;
    return DEC ? -1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < NS; s++) begin last[i][s] = NM - 1; lko[i][s] = -1; end
      for (int m = 0; m < NM; m++) wrerr[i][m] = 1'b0;
    end
    for (int k = 0; k < 6; k++) pend[k].delete();
  endtask

  // Expected outputs from the arbitration rules: lock owner first, else nearest after last winner (RR) or lowest index.
  task automatic model_check(int i);
    logic [2:0] eg, erv, eerr;
    logic [3:0] er, ew;
    logic [127:0] ea, ed;
    logic [15:0] es;
    logic [95:0] edo;
    int o, best, d, w, q;
    eg = '0; erv = '0; eerr = '0; er = '0; ew = '0; ea = '0; ed = '0; es = '0; edo = '0;
    for (int s = 0; s < NS; s++) begin
      win[i][s] = -1; held[i][s] = 1'b0;
      o = lko[i][s];
      if (o >= 0 && req[o] && lock[o] && tgt_of(o) == s) begin
        win[i][s] = o; held[i][s] = 1'b1;
      end else begin
        best = NM;
        for (int m = 0; m < NM; m++) begin
          if (req[m] && tgt_of(m) == s) begin
            d = (i == 0) ? (m - last[i][s] - 1 + 2*NM) % NM : m;
            if (d < best) begin best = d; win[i][s] = m; end
          end
        end
      end
      if (win[i][s] >= 0) begin
        w = win[i][s];
        eg[w] = 1'b1; er[s] = rd[w]; ew[s] = wr[w];
        ea[s*32 +: 32] = addr[w*32 +: 32];
        es[s*4 +: 4]   = size[w*4 +: 4];
        ed[s*32 +: 32] = din[w*32 +: 32];
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (req[m] && tgt_of(m) < 0) eg[m] = 1'b1;
      q = i*3 + m;
      if (pend[q].size() > 0 && pend[q][0].due == cyc) begin
        erv[m] = 1'b1;
        if (pend[q][0].sl < 0) begin edo[m*32 +: 32] = 32'hDEAD_BEEF; eerr[m] = 1'b1; end
        else edo[m*32 +: 32] = sdout[pend[q][0].sl*32 +: 32];
      end
      if (wrerr[i][m]) eerr[m] = 1'b1;
    end
    mgnt[i] = eg;
    chk($sformatf("u%0d gnt", i), gnt[i], eg);
    chk($sformatf("u%0d s_read", i), srd[i], er);
    chk($sformatf("u%0d s_write", i), swr[i], ew);
    chk($sformatf("u%0d s_addr", i), saddr[i], ea);
    chk($sformatf("u%0d s_size", i), ssz[i], es);
    chk($sformatf("u%0d s_din", i), sdin[i], ed);
    chk($sformatf("u%0d rvalid", i), rv[i], erv);
    chk($sformatf("u%0d dout", i), dout[i], edo);
    chk($sformatf("u%0d err", i), err[i], eerr);
  endtask

  task automatic model_commit(int i);
    int q;
    for (int s = 0; s < NS; s++) begin
      if (win[i][s] >= 0) begin
        if (!held[i][s]) last[i][s] = win[i][s];
        lko[i][s] = lock[win[i][s]] ? win[i][s] : -1;
      end else lko[i][s] = -1;
    end
    for (int m = 0; m < NM; m++) begin
      q = i*3 + m;
      if (pend[q].size() > 0 && pend[q][0].due == cyc) void'(pend[q].pop_front());
      if (mgnt[i][m] && rd[m]) pend[q].push_back('{cyc + ((i == 0) ? 1 : 2), tgt_of(m)});
      wrerr[i][m] = mgnt[i][m] && wr[m] && (tgt_of(m) < 0);
    end
  endtask

  task automatic step();
    #1;
    model_check(0); model_check(1);
    model_commit(0); model_commit(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    req = '0; lock = '0; rd = '0; wr = '0; addr = '0; size = '0; din = '0;
  endtask

  initial begin
    npass = 0; nchk = 0; cyc = 0;
    rst_n = 1'b0;
    idle();
    sdout = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    model_reset();
    nibs = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hF};
    tbl[0] = '{3'b101, 3'b000, 3'b001, 3'b100, 32'h1000_0010, 32'h0, 32'h2000_4000, 3'b101, 3'b101, 3'b000, 4'b0001, 4'b0010};
    tbl[1] = '{3'b000, 3'b000, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 3'b001, 4'b0000, 4'b0000};
    for (int r = 0; r < 6; r++) begin
      tbl[2+r] = '{3'b111, 3'b000, 3'b111, 3'b000, 32'h2000_0000, 32'h2000_0004, 32'h2000_0008,
                   3'b001 << (r % 3), 3'b001, (r == 0) ? 3'b000 : 3'b001 << ((r - 1) % 3), 4'b0010, 4'b0000};
    end
    tbl[8]  = '{3'b010, 3'b010, 3'b000, 3'b010, 32'h0, 32'h4000_0000, 32'h0, 3'b010, 3'b010, 3'b100, 4'b0000, 4'b0100};
    for (int r = 9; r < 12; r++)
      tbl[r] = '{3'b011, 3'b010, 3'b000, 3'b011, 32'h4000_0000, 32'h4000_0000, 32'h0, 3'b010, 3'b010, 3'b000, 4'b0000, 4'b0100};
    tbl[12] = '{3'b011, 3'b000, 3'b000, 3'b011, 32'h4000_0000, 32'h4000_0000, 32'h0, 3'b001, 3'b001, 3'b000, 4'b0000, 4'b0100};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 3'b000, 4'b0000, 4'b0000};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset rvalid", rv[i], 3'b000);
      chk("reset err", err[i], 3'b000);
      chk("reset dout", dout[i], 96'h0);
      chk("reset gnt", gnt[i], 3'b000);
    end
    @(negedge clk);

    // Directed vectors: concurrency, round-robin vs fixed order, lock hold and release.
    size = 12'h3CF;
    din  = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    for (int r = 0; r < 14; r++) begin
      req = tbl[r].req; lock = tbl[r].lock; rd = tbl[r].rd; wr = tbl[r].wr;
      addr = {tbl[r].a2, tbl[r].a1, tbl[r].a0};
      #1;
      chk($sformatf("tbl%0d gnt_rr", r), gnt[0], tbl[r].g_rr);
      chk($sformatf("tbl%0d gnt_fp", r), gnt[1], tbl[r].g_fp);
      chk($sformatf("tbl%0d rvalid_rr", r), rv[0], tbl[r].rv_rr);
      chk($sformatf("tbl%0d s_read", r), srd[0], tbl[r].srd);
      chk($sformatf("tbl%0d s_write", r), swr[0], tbl[r].swr);
      step();
    end

    // RD_LAT=2 return from slave 3, then the same read cut off by a reset pulse.
    idle();
    sdout[127:96] = 32'hA5A5_0001;
    req = 3'b001; rd = 3'b001; addr[31:0] = 32'h8000_0000;
    step();
    idle();
    step();
    #1;
    chk("lat2 rvalid", rv[1][0], 1'b1);
    chk("lat2 dout", dout[1][31:0], 32'hA5A5_0001);
    step();
    req = 3'b001; rd = 3'b001; addr[31:0] = 32'h8000_0000;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstmid rvalid_rr", rv[0], 3'b000);
    chk("rstmid rvalid_fp", rv[1], 3'b000);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid +2 rvalid", rv[1], 3'b000);
    chk("rstmid +2 dout", dout[1], 96'h0);
    step();
    step();

    // Unmapped read: error reply with the feature, slave 0 otherwise.
    sdout[31:0] = 32'h0BAD_0000;
    req = 3'b001; rd = 3'b001; addr[31:0] = 32'hF000_0000;
    #1;
    chk("unmapped gnt", gnt[0][0], 1'b1);
    chk("unmapped s_read", srd[0], DEC ? 4'b0000 : 4'b0001);
    step();
    idle();
    #1;
    chk("unmapped rvalid", rv[0][0], 1'b1);
    chk("unmapped err", err[0][0], DEC);
    chk("unmapped dout", dout[0][31:0], DEC ? 32'hDEAD_BEEF : 32'h0BAD_0000);
    step();
    step();

    for (int n = 0; n < 800; n++) begin
      req  = 3'($urandom);
      lock = 3'($urandom) & 3'($urandom);
      rd   = 3'($urandom);
      wr   = 3'($urandom);
      for (int m = 0; m < NM; m++)
        addr[m*32 +: 32] = {nibs[$urandom_range(0, 9)], 28'($urandom)};
      size  = 12'($urandom);
      din   = {$urandom, $urandom, $urandom};
      sdout = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/bus_xbar.md
Name: bus_xbar

Overview:
- Parametrised NUM_M-master x NUM_S-slave crossbar for the SoC memory bus.
- Successor to the fixed SPI/DMEM/DMA system bus.
- Adds:
  - per-slave arbitration, so masters targeting different slaves proceed in the same cycle;
  - round-robin or fixed-priority mode;
  - master lock for back-to-back transfers;
  - parametrised read latency with registered response routing.
- Sits between core/SPI/DMA masters and the SRAM/UART/PIM slaves.

Parameters:
- NUM_M, 3, number of masters; index 0 is highest fixed priority.
- NUM_S, 4, number of slaves.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, slave read latency in cycles (1..4).
- ARB_RR, 1, 1 = round-robin per slave, 0 = fixed priority (lowest index wins).
- S_BASE, {4'h8,4'h4,4'h2,4'h1}, packed 4-bit addr[31:28] match value per slave; slave s uses bits [4s+3:4s].

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m_req  in  NUM_M  master request
- i_m_lock  in  NUM_M  hold grant into next cycle
- o_m_gnt  out  NUM_M  request accepted this cycle
- i_m_addr  in  NUM_M*ADDR_W  master address
- i_m_write  in  NUM_M  write strobe
- i_m_read  in  NUM_M  read strobe
- i_m_size  in  NUM_M*4  byte enables
- i_m_din  in  NUM_M*DATA_W  write data
- o_m_dout  out  NUM_M*DATA_W  read data
- o_m_rvalid  out  NUM_M  read data valid
- o_m_err  out  NUM_M  decode error (BUS_DECERR_EN only; tied 0 otherwise)
- o_s_addr  out  NUM_S*ADDR_W  slave address
- o_s_write  out  NUM_S  slave write strobe
- o_s_read  out  NUM_S  slave read strobe
- o_s_size  out  NUM_S*4  slave byte enables
- o_s_din  out  NUM_S*DATA_W  slave write data
- i_s_dout  in  NUM_S*DATA_W  slave read data

Behaviour:
- Decode (combinational):
  - target(m) = the slave s with S_BASE[s] == i_m_addr[m][31:28].
  - No match: handling per Optional Feature.
  - Multiple matches: lowest s wins.
- Per-slave arbitration, same cycle:
  - Candidates are masters with i_m_req=1 targeting s.
  - ARB_RR=1: winner is the first candidate after rr_ptr[s], searching circularly.
  - ARB_RR=0: winner is the lowest-index candidate.
- Lock:
  - lock_own[s] valid means that master wins s unconditionally while it still requests s.
  - Lock releases when the owner drops i_m_req, drops i_m_lock, or retargets another slave; normal arbitration applies that same cycle.
- o_m_gnt[m] = 1 iff m wins its target this cycle. Multiple masters on distinct slaves are granted concurrently.
- Slave outputs:
  - A granted slave gets the winner's addr/write/read/size/din unregistered.
  - An ungranted slave gets all zeros; o_s_read and o_s_write are never asserted without a grant.
- Registered state, updated each posedge:
  - rr_ptr[s] <= winner when granted and the winner is not lock-held.
  - lock_own[s] <= winner if i_m_lock[winner] is set, else invalid.
- Read return:
  - A granted read pushes {valid, slave index} into a per-master RD_LAT-deep shift pipeline.
  - At the pipeline output: o_m_rvalid[m] = 1 and o_m_dout[m] = i_s_dout[slave]. Both are combinational from the pipeline tap.
  - Otherwise o_m_dout[m] = 0 and o_m_rvalid[m] = 0.
- Write latency 0: the slave samples on the granted cycle. No write response.
- Back-to-back reads from one master return in order, one per cycle.
- Reset (asynchronous): rr_ptr = NUM_M-1 (so master 0 wins first), lock_own invalid, pipelines cleared. o_m_rvalid, o_m_err and o_m_dout read 0 until new reads complete. Reset mid-read discards in-flight returns.
- Read and write asserted together are forwarded unchanged; the slave defines the behaviour.

Optional Feature:
- Macro: BUS_DECERR_EN.
- Defined:
  - An unmapped access is granted immediately and goes to no slave.
  - A read pushes an error tag and returns o_m_dout = 32'hDEAD_BEEF with o_m_rvalid=1 and o_m_err=1 after RD_LAT cycles.
  - A write pulses o_m_err one cycle after the grant.
- Undefined: unmapped accesses route to slave 0 (legacy default-to-DMEM behaviour), and o_m_err is constant 0.

Test Plan:
- Concurrency: M0 reads 0x1000_0010, M2 writes 0x2000_4000, same cycle → both gnt=1. Slave 0 read and slave 1 write both strobed; M0 rvalid with slave 0 data 1 cycle later.
- Round-robin (ARB_RR=1): M0, M1 and M2 all request slave 1 continuously for 6 cycles → grant order 0,1,2,0,1,2.
- Fixed priority (ARB_RR=0), same stimulus as round-robin → M0 granted all 6 cycles; M1 and M2 gnt=0.
- Lock: M1 holds lock on slave 2 for 4 cycles while M0 also requests → M1 granted 4 cycles. M0 granted the cycle M1 drops i_m_lock.
- Read latency and reset (RD_LAT=2): M0 reads slave 3, returning 0xA5A5_0001 → rvalid on cycle +2 with that data. Asserting reset at +1 → no rvalid and dout=0.
- BUS_DECERR_EN read of 0xF000_0000 → gnt=1, no slave strobe, err=1, dout=0xDEAD_BEEF at +RD_LAT. Without the macro, slave 0 is strobed instead.
